pwm_capture: RTL
================

// Module: pwm_capture
// PURPOSE
//  Measures an external PWM signal: high time and period, in clk ticks.
//  Decoder counterpart of the PWM generator. Its ancho_medido output uses the
//  same tick unit as the generator's ancho_pulso input.
//  Used for loopback self-test and for reading fan/servo feedback lines.
//  Flags a missing signal (line stuck) and reports the static level.
// PARAMETERS
//  f_clk      50_000_000  clock frequency, Hz
//  f_pwm_min  1_000       slowest valid PWM, Hz
//  (local) TIMEOUT_TICKS = f_clk/f_pwm_min = 50_000; ANCHO_CONTADOR = $clog2(TIMEOUT_TICKS+1) = 16
// PORTS
//  clk            in   1               system clock
//  reset_n        in   1               reset: synchronous, active-low
//  pwm_in         in   1               asynchronous PWM input
//  ancho_medido   out  ANCHO_CONTADOR  last measured high time, ticks
//  periodo_medido out  ANCHO_CONTADOR  last measured period, ticks
//  medida_valida  out  1               1-cycle pulse: new ancho/periodo pair
//  sin_senal      out  1               no edge seen for TIMEOUT_TICKS
//  nivel_estatico out  1               synced pwm_in level, latched at timeout
// BEHAVIOUR
//  - pwm_in passes a 2-FF synchronizer (s1,s2), then a delay reg s3.
//    rise = s2&~s3, fall = ~s2&s3. Sync regs reset to 0.
//  - Edge latency: pwm_in transition -> rise/fall at 3rd clk edge.
//  - Counter cnt: set to 1 on a rise; otherwise cnt+1, saturating at TIMEOUT_TICKS.
//    It also runs in the wait states. Any fall resets it to 1 in the wait states only.
//  - FSM states:
//      ESPERA_BAJADA (reset)  fall -> ESPERA_SUBIDA
//      ESPERA_SUBIDA          rise -> ALTO
//      ALTO                   fall: latch h=cnt -> BAJO
//      BAJO                   rise: ancho_medido<=h, periodo_medido<=cnt,
//                             medida_valida<=1 (next cycle) -> ALTO
//  - Waiting for a fall first discards any partial pulse caused by reset/sync init.
//    First valid therefore needs fall, rise, fall, rise.
//  - Counting: a rise at cycle t0 and fall at t0+H gives ancho=H.
//    The next rise at t0+P gives periodo=P.
//  - Latency: medida_valida and the updated outputs appear 1 clk after the rise
//    cycle. Outputs hold between pulses.
//  - Timeout: cnt==TIMEOUT_TICKS with no edge this cycle gives, next cycle:
//    sin_senal<=1, nivel_estatico<=s2, FSM -> ESPERA_BAJADA. No valid pulse.
//    ancho/periodo are held.
//  - An edge in the same cycle as cnt==TIMEOUT_TICKS wins.
//    A rise in BAJO still emits periodo=TIMEOUT_TICKS.
//  - sin_senal clears on the next medida_valida, never earlier.
//  - A fall in ESPERA_SUBIDA, or a rise in ESPERA_BAJADA, is ignored except for cnt.
//  - Reset (sync, low at clk edge) zeroes all outputs, cnt, h and sync regs, and
//    sets the FSM to ESPERA_BAJADA. Mid-measurement state is discarded.
//  - Outputs are registered; no combinational path from pwm_in.
// TESTING
//  1. 25 kHz, 50% (high 1000/low 1000 clk) -> 1st valid after 2nd rise;
//     ancho=1000, periodo=2000; valid every 2000 clk.
//  2. Width step 500->1500 ticks, period 2000 -> one valid with 500, the next with 1500;
//     never a mixed value.
//  3. pwm_in held 0 after reset -> sin_senal=1 and nivel_estatico=0 at
//     TIMEOUT_TICKS+1 clk after the last edge/reset; no valid.
//  4. Input stuck 1 after running -> sin_senal=1, nivel_estatico=1, old ancho/periodo held.
//     Restart -> sin_senal clears with the first valid.
//  5. Reset pulse mid high phase -> outputs 0. Input high at release produces no
//     spurious measurement; first valid matches the true pulse.
//  6. Period exactly TIMEOUT_TICKS (50_000), high 1 tick -> valid, ancho=1,
//     periodo=50_000, sin_senal stays 0.

Source files
------------

// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM line and its capture block.
// The master side drives the PWM line and reads the measurement results.
interface pwm_capture_if #(
    parameter int W = 16
);
    logic         pwm_in;
    logic [W-1:0] ancho_medido;
    logic [W-1:0] periodo_medido;
    logic         medida_valida;
    logic         sin_senal;
    logic         nivel_estatico;

    modport master (
        output pwm_in,
        input  ancho_medido,
        input  periodo_medido,
        input  medida_valida,
        input  sin_senal,
        input  nivel_estatico
    );

    modport slave (
        input  pwm_in,
        output ancho_medido,
        output periodo_medido,
        output medida_valida,
        output sin_senal,
        output nivel_estatico
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of pwm_in in clk ticks.
// It flags a stuck line after TIMEOUT_TICKS and reports the static level.
module pwm_capture #(
    parameter int unsigned F_CLK     = 50_000_000,
    parameter int unsigned F_PWM_MIN = 1_000
) (
    input  logic         clk,
    input  logic         reset_n,
    pwm_capture_if.slave io_pwm
);
    localparam int unsigned TIMEOUT_TICKS  = F_CLK / F_PWM_MIN;
    localparam int unsigned ANCHO_CONTADOR = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [ANCHO_CONTADOR-1:0] C_TIMEOUT =
        ANCHO_CONTADOR'(TIMEOUT_TICKS);
    localparam logic [ANCHO_CONTADOR-1:0] C_UNO = ANCHO_CONTADOR'(1);

    typedef enum logic [1:0] {
        ESPERA_BAJADA,
        ESPERA_SUBIDA,
        ALTO,
        BAJO
    } estado_t;

    estado_t r_estado;
    estado_t w_estado_nxt;

    logic r_s1;
    logic r_s2;
    logic r_s3;

    logic [ANCHO_CONTADOR-1:0] r_cnt;
    logic [ANCHO_CONTADOR-1:0] w_cnt_nxt;
    logic [ANCHO_CONTADOR-1:0] r_h;
    logic [ANCHO_CONTADOR-1:0] w_h_nxt;
    logic [ANCHO_CONTADOR-1:0] r_ancho;
    logic [ANCHO_CONTADOR-1:0] w_ancho_nxt;
    logic [ANCHO_CONTADOR-1:0] r_periodo;
    logic [ANCHO_CONTADOR-1:0] w_periodo_nxt;

    logic r_valida;
    logic w_valida_nxt;
    logic r_sin;
    logic w_sin_nxt;
    logic r_nivel;
    logic w_nivel_nxt;

    logic w_rise;
    logic w_fall;
    logic w_espera;
    logic w_timeout;

    assign w_rise    = r_s2 & ~r_s3;
    assign w_fall    = ~r_s2 & r_s3;
    assign w_espera  = (r_estado == ESPERA_BAJADA) ||
                       (r_estado == ESPERA_SUBIDA);
    assign w_timeout = (r_cnt == C_TIMEOUT) && !w_rise && !w_fall;

    assign io_pwm.ancho_medido   = r_ancho;
    assign io_pwm.periodo_medido = r_periodo;
    assign io_pwm.medida_valida  = r_valida;
    assign io_pwm.sin_senal      = r_sin;
    assign io_pwm.nivel_estatico = r_nivel;

    // Two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= io_pwm.pwm_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_estado <= ESPERA_BAJADA;
        end else begin
            r_estado <= w_estado_nxt;
        end
    end

    // Counter, latched high time and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_h       <= '0;
            r_ancho   <= '0;
            r_periodo <= '0;
            r_valida  <= 1'b0;
            r_sin     <= 1'b0;
            r_nivel   <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_h       <= w_h_nxt;
            r_ancho   <= w_ancho_nxt;
            r_periodo <= w_periodo_nxt;
            r_valida  <= w_valida_nxt;
            r_sin     <= w_sin_nxt;
            r_nivel   <= w_nivel_nxt;
        end
    end

    // Next-state, counter and measurement decode; timeout beats the FSM
    always_comb begin
        w_estado_nxt  = r_estado;
        w_cnt_nxt     = r_cnt;
        w_h_nxt       = r_h;
        w_ancho_nxt   = r_ancho;
        w_periodo_nxt = r_periodo;
        w_valida_nxt  = 1'b0;
        w_sin_nxt     = r_sin;
        w_nivel_nxt   = r_nivel;

        if (w_rise) begin
            w_cnt_nxt = C_UNO;
        end else if (w_fall && w_espera) begin
            w_cnt_nxt = C_UNO;
        end else if (r_cnt != C_TIMEOUT) begin
            w_cnt_nxt = r_cnt + C_UNO;
        end

        if (w_timeout) begin
            w_sin_nxt    = 1'b1;
            w_nivel_nxt  = r_s2;
            w_estado_nxt = ESPERA_BAJADA;
        end else begin
            unique case (r_estado)
                ESPERA_BAJADA: begin
                    if (w_fall) w_estado_nxt = ESPERA_SUBIDA;
                end
                ESPERA_SUBIDA: begin
                    if (w_rise) w_estado_nxt = ALTO;
                end
                ALTO: begin
                    if (w_fall) begin
                        w_h_nxt      = r_cnt;
                        w_estado_nxt = BAJO;
                    end
                end
                BAJO: begin
                    if (w_rise) begin
                        w_ancho_nxt   = r_h;
                        w_periodo_nxt = r_cnt;
                        w_valida_nxt  = 1'b1;
                        w_sin_nxt     = 1'b0;
                        w_estado_nxt  = ALTO;
                    end
                end
                default: w_estado_nxt = ESPERA_BAJADA;
            endcase
        end
    end
endmodule
